// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module : pipe_pkg
//  Brief  : Shared types and helpers for the elastic pipeline register.
//  Rev    : 1.0  initial release
// ============================================================================
package pipe_pkg;

   // Occupancy state of one skid stage.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b01,
      FULL  = 2'b10
   } stage_state_e;

   // Counter width able to represent 0..2*depth.
   function automatic int cnt_width(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/skid_stage.sv
`default_nettype none
// ============================================================================
//  Module : skid_stage
//  Brief  : One full-throughput skid stage (main + skid slot) with fully
//           registered valid/ready on both sides.
//  Rev    : 1.0  initial release
// ============================================================================
module skid_stage
   import pipe_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_up_valid,
   output logic             o_up_ready,
   input  logic [WIDTH-1:0] i_up_data,
   output logic             o_dn_valid,
   input  logic             i_dn_ready,
   output logic [WIDTH-1:0] o_dn_data
);

   stage_state_e     r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             r_up_ready;
   logic             r_dn_valid;

   logic             w_in_xfer;
   logic             w_out_xfer;

   // Handshake outputs come straight from registers, so ready never depends
   // combinationally on the downstream ready.
   assign w_in_xfer  = i_up_valid & r_up_ready;
   assign w_out_xfer = r_dn_valid & i_dn_ready;

   assign o_up_ready = r_up_ready;
   assign o_dn_valid = r_dn_valid;
   assign o_dn_data  = r_main;

   // Stage FSM: state, data slots and the registered handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_main     <= INIT;
         r_skid     <= INIT;
         r_up_ready <= 1'b1;
         r_dn_valid <= 1'b0;
      end else if (i_flush) begin
         // Entries are dropped; data slots keep their stale contents.
         r_state    <= EMPTY;
         r_up_ready <= 1'b1;
         r_dn_valid <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  r_state    <= BUSY;
                  r_main     <= i_up_data;
                  r_dn_valid <= 1'b1;
               end
            end
            BUSY: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_main <= i_up_data;
               end else if (w_in_xfer) begin
                  // Downstream stalled: park the new word in the skid slot.
                  r_state    <= FULL;
                  r_skid     <= i_up_data;
                  r_up_ready <= 1'b0;
               end else if (w_out_xfer) begin
                  r_state    <= EMPTY;
                  r_dn_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_out_xfer) begin
                  r_state    <= BUSY;
                  r_main     <= r_skid;
                  r_up_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= EMPTY;
               r_up_ready <= 1'b1;
               r_dn_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// ============================================================================
//  Module : pipe_reg_elastic
//  Brief  : Elastic pipeline register built from DEPTH skid stages in series,
//           with an occupancy counter and synchronous flush.
//  Rev    : 1.0  initial release
// ============================================================================
module pipe_reg_elastic
   import pipe_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 1,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
   parameter int               CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * DEPTH);

   // Link k feeds stage k; link DEPTH is the block output.
   logic [DEPTH:0]   w_valid;
   logic [DEPTH:0]   w_ready;
   logic [WIDTH-1:0] w_data [0:DEPTH];

   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [CNT_W-1:0] r_count;

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("pipe_reg_elastic: DEPTH must be at least 1");
      end
   endgenerate

   assign w_valid[0]     = in_valid;
   assign w_data[0]      = in_data;
   assign in_ready       = w_ready[0];
   assign w_ready[DEPTH] = out_ready;
   assign out_valid      = w_valid[DEPTH];
   assign out_data       = w_data[DEPTH];

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         skid_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
         ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flush    (flush),
            .i_up_valid (w_valid[k]),
            .o_up_ready (w_ready[k]),
            .i_up_data  (w_data[k]),
            .o_dn_valid (w_valid[k+1]),
            .i_dn_ready (w_ready[k+1]),
            .o_dn_data  (w_data[k+1])
         );
      end
   endgenerate

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;
   assign count      = r_count;

   // Occupancy counter: +1 per accepted word, -1 per delivered word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         r_count <= r_count + CNT_ONE;
      end else if (w_out_xfer && !w_in_xfer) begin
         r_count <= r_count - CNT_ONE;
      end
   end

`ifndef SYNTHESIS
   a_in_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready) |=> $stable(in_data));

   a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= CNT_MAX);

   a_cnt_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(r_count == '0 && w_out_xfer && !w_in_xfer && !flush));
`endif

endmodule
`default_nettype wire
